// File: rtl/hcu_arbiter.sv
// Round-robin arbiter that shares one hash core among NUM_PORTS AXI-Stream requesters.
// One message is outstanding at a time; the digest is routed back tagged with the owner index.

module hcu_arbiter #(
  parameter int NUM_PORTS            = 4,
  parameter int C_S_AXIS_DATA_WIDTH  = 64,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_DATA_WIDTH  = 512
) (
  input  logic                                       axis_aclk,
  input  logic                                       axis_resetn,

  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                       s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                       s_axis_tlast,
  output logic [NUM_PORTS-1:0]                       s_axis_tready,

  output logic [C_S_AXIS_DATA_WIDTH-1:0]             hcu_s_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]            hcu_s_axis_tuser,
  output logic                                       hcu_s_axis_tvalid,
  output logic                                       hcu_s_axis_tlast,
  input  logic                                       hcu_s_axis_tready,

  input  logic [C_M_AXIS_DATA_WIDTH-1:0]             hcu_m_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]            hcu_m_axis_tuser,
  input  logic                                       hcu_m_axis_tvalid,
  input  logic                                       hcu_m_axis_tlast,
  output logic                                       hcu_m_axis_tready,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]            m_axis_tuser,
  output logic                                       m_axis_tvalid,
  output logic                                       m_axis_tlast,
  output logic [1:0]                                 m_axis_tid,
  input  logic                                       m_axis_tready,

  output logic                                       busy
);

  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_STREAM      = 2'd1,
    ST_WAIT_DIGEST = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W:0]     cand;
  logic [IDX_W-1:0]   rr_after_grant;

  logic [C_S_AXIS_DATA_WIDTH-1:0]  sel_tdata;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] sel_tuser;
  logic                            sel_tvalid;
  logic                            sel_tlast;

  logic in_stream;
  logic in_wait;

  // Rotating search starting at rr_ptr; the candidate is folded back into 0..NUM_PORTS-1
  // so non-power-of-two port counts never produce an out-of-range grant.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first so no latch is inferred.
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_PORTS)) begin
        cand = cand - (IDX_W+1)'(NUM_PORTS);
      end
      if (!arb_found && s_axis_tvalid[cand[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    sel_tdata  = '0;
    sel_tuser  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant_q == IDX_W'(k)) begin
        sel_tdata  = s_axis_tdata[k*C_S_AXIS_DATA_WIDTH +: C_S_AXIS_DATA_WIDTH];
        sel_tuser  = s_axis_tuser[k*C_S_AXIS_TUSER_WIDTH +: C_S_AXIS_TUSER_WIDTH];
        sel_tvalid = s_axis_tvalid[k];
        sel_tlast  = s_axis_tlast[k];
      end
    end
  end

  assign rr_after_grant = (grant_q == IDX_W'(NUM_PORTS-1)) ? '0 : grant_q + 1'b1;
  assign in_stream      = (state_q == ST_STREAM);
  assign in_wait        = (state_q == ST_WAIT_DIGEST);

  // Data paths are pass-through; only the handshake qualifiers depend on state.
  always_comb begin
    hcu_s_axis_tdata  = sel_tdata;
    hcu_s_axis_tuser  = sel_tuser;
    hcu_s_axis_tvalid = in_stream & sel_tvalid;
    hcu_s_axis_tlast  = in_stream & sel_tlast;

    s_axis_tready = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (in_stream && grant_q == IDX_W'(k)) begin
        s_axis_tready[k] = hcu_s_axis_tready;
      end
    end

    m_axis_tdata      = hcu_m_axis_tdata;
    m_axis_tuser      = hcu_m_axis_tuser;
    m_axis_tvalid     = in_wait & hcu_m_axis_tvalid;
    m_axis_tlast      = in_wait & hcu_m_axis_tlast;
    m_axis_tid        = in_wait ? grant_q : '0;
    hcu_m_axis_tready = in_wait & m_axis_tready;

    busy = (state_q != ST_IDLE);
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // Grant is locked until the last beat is accepted; a stalled requester just waits.
        if (hcu_s_axis_tvalid && hcu_s_axis_tready && hcu_s_axis_tlast) begin
          state_d = ST_WAIT_DIGEST;
        end
      end
      ST_WAIT_DIGEST: begin
        if (hcu_m_axis_tvalid && m_axis_tready) begin
          state_d  = ST_IDLE;
          rr_ptr_d = rr_after_grant;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_hcu_arbiter.sv
// Scoreboard bench for hcu_arbiter: directed requester traffic, a simple hash-core model,
// and monitors that compare every beat reaching the core and every routed digest.

module tb_hcu_arbiter;

  localparam int NP = 4;
  localparam int DW = 64;
  localparam int UW = 128;
  localparam int MW = 512;

  localparam logic [7:0] SHA256 = 8'h01;
  localparam logic [7:0] SHA512 = 8'h02;

  logic                 axis_aclk = 1'b0;
  logic                 axis_resetn;
  logic [NP*DW-1:0]     s_axis_tdata;
  logic [NP*UW-1:0]     s_axis_tuser;
  logic [NP-1:0]        s_axis_tvalid;
  logic [NP-1:0]        s_axis_tlast;
  logic [NP-1:0]        s_axis_tready;
  logic [DW-1:0]        hcu_s_axis_tdata;
  logic [UW-1:0]        hcu_s_axis_tuser;
  logic                 hcu_s_axis_tvalid;
  logic                 hcu_s_axis_tlast;
  logic                 hcu_s_axis_tready;
  logic [MW-1:0]        hcu_m_axis_tdata;
  logic [UW-1:0]        hcu_m_axis_tuser;
  logic                 hcu_m_axis_tvalid;
  logic                 hcu_m_axis_tlast;
  logic                 hcu_m_axis_tready;
  logic [MW-1:0]        m_axis_tdata;
  logic [UW-1:0]        m_axis_tuser;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic [1:0]           m_axis_tid;
  logic                 m_axis_tready;
  logic                 busy;

  hcu_arbiter #(
    .NUM_PORTS(NP), .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .C_M_AXIS_DATA_WIDTH(MW)
  ) dut (
    .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .hcu_s_axis_tdata(hcu_s_axis_tdata), .hcu_s_axis_tuser(hcu_s_axis_tuser),
    .hcu_s_axis_tvalid(hcu_s_axis_tvalid), .hcu_s_axis_tlast(hcu_s_axis_tlast),
    .hcu_s_axis_tready(hcu_s_axis_tready),
    .hcu_m_axis_tdata(hcu_m_axis_tdata), .hcu_m_axis_tuser(hcu_m_axis_tuser),
    .hcu_m_axis_tvalid(hcu_m_axis_tvalid), .hcu_m_axis_tlast(hcu_m_axis_tlast),
    .hcu_m_axis_tready(hcu_m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid), .m_axis_tready(m_axis_tready),
    .busy(busy)
  );

  always #5 axis_aclk = ~axis_aclk;

  typedef struct {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    logic [MW-1:0] data;
    logic [UW-1:0] user;
    logic [1:0]    tid;
  } dig_t;

  beat_t exp_beats[$];
  dig_t  exp_digs[$];

  int checks = 0;
  int errors = 0;
  int digests_seen = 0;

  // Requester models: req_left messages of req_len beats, message serials from req_seq.
  int         req_left [NP];
  int         req_len  [NP];
  int         req_idx  [NP];
  int         req_seq  [NP];
  logic [7:0] req_codec[NP];

  // Hash-core and sink models.
  logic          core_ready;
  logic          sink_ready;
  logic          core_valid;
  logic          inject;
  logic [MW-1:0] core_data;
  logic [UW-1:0] core_user;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input int k, input int seq, input int idx);
    return {8'(k), 8'(seq), 32'h5EED_0000 ^ 32'(seq * 7), 16'(idx)};
  endfunction

  function automatic logic [UW-1:0] beat_user(input int k, input int seq, input logic [7:0] codec);
    return {codec, 104'h0123_4567_89AB_CDEF_0011_2233_44, 8'(k), 8'(seq)};
  endfunction

  function automatic logic [MW-1:0] digest_of(input logic [DW-1:0] last_data);
    return {8{~last_data}};
  endfunction

  task automatic drive();
    for (int k = 0; k < NP; k++) begin
      s_axis_tvalid[k]          = (req_left[k] > 0);
      s_axis_tlast[k]           = (req_idx[k] == req_len[k] - 1);
      s_axis_tdata[k*DW +: DW]  = beat_data(k, req_seq[k], req_idx[k]);
      s_axis_tuser[k*UW +: UW]  = beat_user(k, req_seq[k], req_codec[k]);
    end
    hcu_s_axis_tready = core_ready;
    m_axis_tready     = sink_ready;
    hcu_m_axis_tvalid = core_valid | inject;
    hcu_m_axis_tlast  = core_valid | inject;
    hcu_m_axis_tdata  = core_data;
    hcu_m_axis_tuser  = core_user;
  endtask

  task automatic issue(input int k, input int len, input int nmsg, input int seq0, input logic [7:0] codec);
    req_left[k]  = nmsg;
    req_len[k]   = len;
    req_idx[k]   = 0;
    req_seq[k]   = seq0;
    req_codec[k] = codec;
    drive();
  endtask

  task automatic push_msg(input int k, input int seq, input int len, input logic [7:0] codec);
    for (int i = 0; i < len; i++) begin
      exp_beats.push_back('{beat_data(k, seq, i), beat_user(k, seq, codec), (i == len - 1)});
    end
    exp_digs.push_back('{digest_of(beat_data(k, seq, len - 1)), beat_user(k, seq, codec), 2'(k)});
  endtask

  task automatic flush_models();
    for (int k = 0; k < NP; k++) begin
      req_left[k] = 0;
      req_idx[k]  = 0;
    end
    core_valid = 1'b0;
    exp_beats.delete();
    exp_digs.delete();
    drive();
  endtask

  // One clock: sample handshakes on the falling edge, advance models just after the rising edge.
  task automatic step();
    logic [NP-1:0] hs;
    logic          last_hs;
    logic          dig_hs;
    logic [DW-1:0] last_data;
    logic [UW-1:0] last_user;
    @(negedge axis_aclk);
    hs        = s_axis_tvalid & s_axis_tready;
    last_hs   = hcu_s_axis_tvalid & hcu_s_axis_tready & hcu_s_axis_tlast;
    dig_hs    = hcu_m_axis_tvalid & hcu_m_axis_tready;
    last_data = hcu_s_axis_tdata;
    last_user = hcu_s_axis_tuser;
    @(posedge axis_aclk);
    #1;
    for (int k = 0; k < NP; k++) begin
      if (hs[k]) begin
        req_idx[k]++;
        if (req_idx[k] == req_len[k]) begin
          req_idx[k] = 0;
          req_left[k]--;
          req_seq[k]++;
        end
      end
    end
    if (dig_hs) core_valid = 1'b0;
    if (last_hs) begin
      core_valid = 1'b1;
      core_data  = digest_of(last_data);
      core_user  = last_user;
    end
    drive();
    #1;
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int  n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = !busy && !core_valid && exp_beats.size() == 0 && exp_digs.size() == 0 &&
             req_left[0] == 0 && req_left[1] == 0 && req_left[2] == 0 && req_left[3] == 0;
    end
    check({name, "_drain"}, done, 1'b1);
  endtask

  // Monitor: every beat accepted by the core and every routed digest is checked against the queues.
  always @(negedge axis_aclk) begin
    if (axis_resetn && hcu_s_axis_tvalid && hcu_s_axis_tready) begin
      if (exp_beats.size() == 0) begin
        check("beat_unexpected", 1'b1, 1'b0);
      end else begin
        beat_t b;
        b = exp_beats.pop_front();
        check("beat_data", hcu_s_axis_tdata, b.data);
        check("beat_user", hcu_s_axis_tuser, b.user);
        check("beat_last", hcu_s_axis_tlast, b.last);
      end
    end
    if (axis_resetn && m_axis_tvalid && m_axis_tready) begin
      digests_seen++;
      if (exp_digs.size() == 0) begin
        check("digest_unexpected", 1'b1, 1'b0);
      end else begin
        dig_t d;
        d = exp_digs.pop_front();
        check("digest_data", m_axis_tdata, d.data);
        check("digest_user", m_axis_tuser, d.user);
        check("digest_tid",  m_axis_tid,   d.tid);
        check("digest_last", m_axis_tlast, 1'b1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dig_target;

    axis_resetn = 1'b0;
    core_ready  = 1'b1;
    sink_ready  = 1'b1;
    core_valid  = 1'b0;
    inject      = 1'b1;
    core_data   = '0;
    core_user   = '0;
    for (int k = 0; k < NP; k++) begin
      req_left[k] = 0; req_len[k] = 1; req_idx[k] = 0; req_seq[k] = 0; req_codec[k] = 8'h00;
    end
    drive();

    // Reset state: outputs forced low even with a digest offered and the sink ready.
    #12;
    check("rst_busy",        busy,              1'b0);
    check("rst_s_tready",    s_axis_tready,     4'b0000);
    check("rst_hcu_tvalid",  hcu_s_axis_tvalid, 1'b0);
    check("rst_hcu_m_tready", hcu_m_axis_tready, 1'b0);
    check("rst_m_tvalid",    m_axis_tvalid,     1'b0);
    check("rst_m_tlast",     m_axis_tlast,      1'b0);
    check("rst_m_tid",       m_axis_tid,        2'd0);
    inject = 1'b0;
    drive();
    step();
    #1 axis_resetn = 1'b1;
    step();
    step();
    check("idle_busy", busy, 1'b0);

    // Port 2 alone, 8-beat SHA-256 message; grant appears exactly one cycle later.
    issue(2, 8, 1, 8'h01, SHA256);
    push_msg(2, 8'h01, 8, SHA256);
    #1;
    check("arb_lat_busy_before",   busy,          1'b0);
    check("arb_lat_tready_before", s_axis_tready, 4'b0000);
    step();
    check("arb_lat_busy_after",   busy,              1'b1);
    check("arb_lat_tready_after", s_axis_tready,     4'b0100);
    check("arb_lat_hcu_tvalid",   hcu_s_axis_tvalid, 1'b1);
    run_until_idle("p2_msg", 40);

    // Single-beat message on port 3 with rr_ptr at 3; pointer then wraps to 0.
    issue(3, 1, 1, 8'h10, SHA256);
    push_msg(3, 8'h10, 1, SHA256);
    step();
    check("single_stream_busy",   busy,              1'b1);
    check("single_stream_tvalid", hcu_s_axis_tvalid, 1'b1);
    check("single_stream_tlast",  hcu_s_axis_tlast,  1'b1);
    check("single_stream_tready", s_axis_tready,     4'b1000);
    step();
    check("single_wait_busy",      busy,              1'b1);
    check("single_wait_hcu_valid", hcu_s_axis_tvalid, 1'b0);
    check("single_wait_tready",    s_axis_tready,     4'b0000);
    check("single_wait_m_tvalid",  m_axis_tvalid,     1'b1);
    check("single_wait_m_tid",     m_axis_tid,        2'd3);
    step();
    check("single_idle_busy", busy, 1'b0);
    run_until_idle("single", 10);

    // All four ports valid continuously: expected grant order 0,1,2,3,0.
    issue(0, 3, 2, 8'h20, SHA256);
    issue(1, 2, 1, 8'h22, SHA512);
    issue(2, 4, 1, 8'h23, SHA256);
    issue(3, 1, 1, 8'h24, SHA512);
    push_msg(0, 8'h20, 3, SHA256);
    push_msg(1, 8'h22, 2, SHA512);
    push_msg(2, 8'h23, 4, SHA256);
    push_msg(3, 8'h24, 1, SHA512);
    push_msg(0, 8'h21, 3, SHA256);
    run_until_idle("all4", 100);

    // Port 1 streaming; port 0 joins mid-message and must stay blocked until port 1's digest.
    dig_target = digests_seen + 1;
    issue(1, 5, 1, 8'h30, SHA256);
    push_msg(1, 8'h30, 5, SHA256);
    n = 0;
    while (req_idx[1] < 2 && n < 20) begin
      step();
      n++;
    end
    check("p1_two_beats", req_idx[1], 2);
    issue(0, 2, 1, 8'h31, SHA256);
    push_msg(0, 8'h31, 2, SHA256);
    #1;
    n = 0;
    while (digests_seen < dig_target && n < 50) begin
      check("p0_blocked", s_axis_tready[0], 1'b0);
      step();
      n++;
    end
    check("p1_digest_seen", digests_seen >= dig_target, 1'b1);
    check("p0_idle_busy",   busy,             1'b0);
    check("p0_idle_tready", s_axis_tready[0], 1'b0);
    step();
    check("p0_granted", s_axis_tready, 4'b0001);
    run_until_idle("p1_p0", 40);

    // Digest back-pressure for 5 cycles, then IDLE the cycle after the sink becomes ready.
    sink_ready = 1'b0;
    issue(2, 3, 1, 8'h40, SHA256);
    push_msg(2, 8'h40, 3, SHA256);
    n = 0;
    while (!m_axis_tvalid && n < 30) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_hcu_m_tready", hcu_m_axis_tready, 1'b0);
      check("bp_m_tvalid",     m_axis_tvalid,     1'b1);
      check("bp_busy",         busy,              1'b1);
      step();
    end
    check("bp_tid", m_axis_tid, 2'd2);
    sink_ready = 1'b1;
    drive();
    #1;
    check("bp_hcu_m_tready_up", hcu_m_axis_tready, 1'b1);
    step();
    check("bp_idle_after", busy, 1'b0);
    run_until_idle("bp", 10);

    // A digest offered while IDLE is neither forwarded nor accepted.
    inject = 1'b1;
    drive();
    #1;
    check("idle_m_tvalid",     m_axis_tvalid,     1'b0);
    check("idle_m_tlast",      m_axis_tlast,      1'b0);
    check("idle_hcu_m_tready", hcu_m_axis_tready, 1'b0);
    check("idle_hcu_s_tvalid", hcu_s_axis_tvalid, 1'b0);
    inject = 1'b0;
    drive();

    // Reset at beat 4 of a 16-beat SHA-512 message on port 1, with rr_ptr at 3.
    issue(1, 16, 1, 8'h50, SHA512);
    push_msg(1, 8'h50, 16, SHA512);
    n = 0;
    while (req_idx[1] < 4 && n < 30) begin
      step();
      n++;
    end
    check("mid_msg_busy",   busy,          1'b1);
    check("mid_msg_tready", s_axis_tready, 4'b0010);
    #1 axis_resetn = 1'b0;
    #1;
    check("async_rst_busy",       busy,              1'b0);
    check("async_rst_s_tready",   s_axis_tready,     4'b0000);
    check("async_rst_hcu_tvalid", hcu_s_axis_tvalid, 1'b0);
    check("async_rst_hcu_tready", hcu_m_axis_tready, 1'b0);
    check("async_rst_m_tvalid",   m_axis_tvalid,     1'b0);
    check("async_rst_m_tid",      m_axis_tid,        2'd0);
    flush_models();
    step();
    step();
    #1 axis_resetn = 1'b1;
    #1;
    check("post_rst_busy", busy, 1'b0);
    // Ports 1 and 3 together: search must restart at port 0, so port 1 wins first.
    issue(1, 2, 1, 8'h60, SHA256);
    issue(3, 2, 1, 8'h61, SHA256);
    push_msg(1, 8'h60, 2, SHA256);
    push_msg(3, 8'h61, 2, SHA256);
    step();
    check("post_rst_grant", s_axis_tready, 4'b0010);
    run_until_idle("post_rst", 40);

    check("beats_left",   exp_beats.size(), 0);
    check("digests_left", exp_digs.size(),  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
